// File: rtl/card_draw_scheduler.sv
// card_draw_scheduler
//   Arbitrates card-draw requests from the player and dealer logic. For each
//   grant it sequences one 24x36 sprite blit. It scans the card ROM
//   (value base + y*24 + x) and plots each returned pixel through the
//   160x120 VGA adapter plot interface.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_p_req/i_p_card/i_p_slot, o_p_ack   player request, card {suit,value}, slot, grant pulse
//   i_d_req/i_d_card/i_d_slot, o_d_ack   dealer request, card, slot, grant pulse
//   o_rom_addr, i_rom_data                card ROM address / pixel (1-cycle latency)
//   o_vga_x, o_vga_y, o_vga_colour, o_vga_plot   VGA adapter plot interface
//   o_busy                high from grant through the done cycle
//   o_done                1-cycle completion pulse
//   o_owner               0 = player, 1 = dealer (valid while busy)
//
// Build option
//   SUIT_TINT_EN  when defined, ink pixels (rom_data == FG_COLOUR) of suit 1/2
//                 cards are recoloured to TINT_COLOUR.
module card_draw_scheduler #(
  parameter int unsigned          X_BASE      = 4,
  parameter int unsigned          SLOT_PITCH  = 28,
  parameter int unsigned          MAX_SLOTS   = 5,
  parameter int unsigned          Y_PLAYER    = 80,
  parameter int unsigned          Y_DEALER    = 8,
  parameter int unsigned          COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0]  FG_COLOUR   = 3'b000,
  parameter logic [COLOUR_W-1:0]  TINT_COLOUR = 3'b100
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_p_req,
  input  logic [5:0]          i_p_card,
  input  logic [2:0]          i_p_slot,
  output logic                o_p_ack,
  input  logic                i_d_req,
  input  logic [5:0]          i_d_card,
  input  logic [2:0]          i_d_slot,
  output logic                o_d_ack,
  output logic [13:0]         o_rom_addr,
  input  logic [COLOUR_W-1:0] i_rom_data,
  output logic [7:0]          o_vga_x,
  output logic [6:0]          o_vga_y,
  output logic [COLOUR_W-1:0] o_vga_colour,
  output logic                o_vga_plot,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_owner
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FLUSH, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_x;
  logic [5:0]  r_y;
  logic [2:0]  r_slot;
  logic        r_owner;
  logic        r_last;      // last granted requester: 0 player, 1 dealer
  logic        r_p_ack;
  logic        r_d_ack;
  logic        r_busy;
  logic        r_done;
  logic        r_plot;
  logic [13:0] r_rom_addr;
  logic [7:0]  r_vga_x;
  logic [6:0]  r_vga_y;
`ifdef SUIT_TINT_EN
  logic [1:0]  r_suit;
`endif

  logic                w_can_grant;
  logic                w_grant_p;
  logic                w_grant_d;
  logic                w_slot_ok;
  logic [5:0]          w_sel_card;
  logic [2:0]          w_sel_slot;
  logic [13:0]         w_base;
  logic [7:0]          w_vga_x;
  logic [6:0]          w_vga_y;
  logic [COLOUR_W-1:0] w_colour;

  // The DONE cycle also arbitrates, so the next ack can follow done directly.
  assign w_can_grant = (r_state == S_IDLE) || (r_state == S_DONE);
  // Round-robin on a tie: the requester that was not granted last wins.
  assign w_grant_p   = w_can_grant && i_p_req && (!i_d_req || r_last);
  assign w_grant_d   = w_can_grant && i_d_req && (!i_p_req || !r_last);
  assign w_sel_card  = w_grant_d ? i_d_card : i_p_card;
  assign w_sel_slot  = w_grant_d ? i_d_slot : i_p_slot;
  assign w_slot_ok   = (32'(w_sel_slot) < MAX_SLOTS);

  always_comb begin
    w_base = '0;
    if (w_sel_card[3:0] >= 4'd1 && w_sel_card[3:0] <= 4'd13)
      w_base = ({10'd0, w_sel_card[3:0]} - 14'd1) * 14'd864;
  end

  assign w_vga_x = 8'(X_BASE + SLOT_PITCH * 32'(r_slot) + 32'(r_x));
  assign w_vga_y = 7'((r_owner ? Y_DEALER : Y_PLAYER) + 32'(r_y));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_slot     <= '0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_p_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_plot     <= 1'b0;
      r_rom_addr <= '0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
`ifdef SUIT_TINT_EN
      r_suit     <= '0;
`endif
    end else begin
      r_p_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_done  <= 1'b0;
      r_plot  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (w_grant_p || w_grant_d) begin
            r_p_ack <= w_grant_p;
            r_d_ack <= w_grant_d;
            r_owner <= w_grant_d;
            r_last  <= w_grant_d;
            r_slot  <= w_sel_slot;
            r_busy  <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
`ifdef SUIT_TINT_EN
            r_suit  <= w_sel_card[5:4];
`endif
            // Invalid slots skip the scan and complete through FLUSH.
            if (w_slot_ok) begin
              r_rom_addr <= w_base;
              r_state    <= S_DRAW;
            end else begin
              r_rom_addr <= '0;
              r_state    <= S_FLUSH;
            end
          end
        end
        S_DRAW: begin
          // Coordinates are registered alongside the ROM read so they line
          // up with rom_data one cycle later.
          r_plot  <= 1'b1;
          r_vga_x <= w_vga_x;
          r_vga_y <= w_vga_y;
          // x runs fastest, so base + y*24 + x advances by exactly one per pixel.
          if (r_x == 5'd23) begin
            r_x <= '0;
            if (r_y == 6'd35) begin
              r_y        <= '0;
              r_rom_addr <= '0;
              r_state    <= S_FLUSH;
            end else begin
              r_y        <= r_y + 6'd1;
              r_rom_addr <= r_rom_addr + 14'd1;
            end
          end else begin
            r_x        <= r_x + 5'd1;
            r_rom_addr <= r_rom_addr + 14'd1;
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_colour = '0;
    if (r_plot) begin
      w_colour = i_rom_data;
`ifdef SUIT_TINT_EN
      if ((r_suit == 2'd1 || r_suit == 2'd2) && i_rom_data == FG_COLOUR)
        w_colour = TINT_COLOUR;
`endif
    end
  end

`ifndef SUIT_TINT_EN
  logic w_unused_tint;
  assign w_unused_tint = ^{i_p_card[5:4], i_d_card[5:4], FG_COLOUR, TINT_COLOUR};
`endif

  assign o_p_ack      = r_p_ack;
  assign o_d_ack      = r_d_ack;
  assign o_rom_addr   = r_rom_addr;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = w_colour;
  assign o_vga_plot   = r_plot;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_owner      = r_owner;

endmodule

// File: tb/tb_card_draw_scheduler.sv
// Scoreboard bench for card_draw_scheduler: stimulus pushes one expected
// transaction per issued grant; the monitor pops it on the ack and then
// checks the ROM address stream, every plot, and the done pulse.
module tb_card_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_req = 1'b0;
  logic        d_req = 1'b0;
  logic [5:0]  p_card = '0;
  logic [5:0]  d_card = '0;
  logic [2:0]  p_slot = '0;
  logic [2:0]  d_slot = '0;
  logic        p_ack;
  logic        d_ack;
  logic [13:0] rom_addr;
  logic [2:0]  rom_data = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;
  logic        owner;

  always #5 clk = ~clk;

  card_draw_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_p_req     (p_req),
    .i_p_card    (p_card),
    .i_p_slot    (p_slot),
    .o_p_ack     (p_ack),
    .i_d_req     (d_req),
    .i_d_card    (d_card),
    .i_d_slot    (d_slot),
    .o_d_ack     (d_ack),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_vga_x     (vga_x),
    .o_vga_y     (vga_y),
    .o_vga_colour(vga_colour),
    .o_vga_plot  (vga_plot),
    .o_busy      (busy),
    .o_done      (done),
    .o_owner     (owner)
  );

`ifdef SUIT_TINT_EN
  localparam bit TINT_EN = 1'b1;
`else
  localparam bit TINT_EN = 1'b0;
`endif

  // Card ROM model: pattern with plenty of 3'b000 ink pixels.
  function automatic logic [2:0] rom_f(input logic [13:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9];
  endfunction

  function automatic logic [2:0] exp_col(input logic [13:0] a, input logic [1:0] s);
    logic [2:0] d;
    d = rom_f(a);
    if (TINT_EN && (s == 2'd1 || s == 2'd2) && d == 3'b000) return 3'b100;
    return d;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  typedef struct {
    bit          owner;
    logic [1:0]  suit;
    int unsigned base;
    int unsigned x0;
    int unsigned y0;
    int unsigned npix;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_vec = 0;
  int          n_err = 0;
  bit          active = 1'b0;
  bit          rst_prev = 1'b0;
  bit          mon_en = 1'b0;
  int unsigned k = 0;
  int unsigned j = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit o, input logic [5:0] c, input int unsigned base,
                              input int unsigned x0, input int unsigned y0,
                              input int unsigned npix);
    exp_t e;
    e.owner = o;
    e.suit  = c[5:4];
    e.base  = base;
    e.x0    = x0;
    e.y0    = y0;
    e.npix  = npix;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_prev) begin
        chk("rst_plot",     32'(vga_plot),   0);
        chk("rst_busy",     32'(busy),       0);
        chk("rst_done",     32'(done),       0);
        chk("rst_acks",     32'({p_ack, d_ack}), 0);
        chk("rst_rom_addr", 32'(rom_addr),   0);
        chk("rst_vga_xy",   32'({vga_x, vga_y}), 0);
        chk("rst_colour",   32'(vga_colour), 0);
        chk("rst_owner",    32'(owner),      0);
        active = 1'b0;
      end else begin
        if (!active) begin
          if (p_ack || d_ack) begin
            if (q.size() == 0) begin
              chk("unexpected_ack", 32'({p_ack, d_ack}), 0);
            end else begin
              cur    = q.pop_front();
              active = 1'b1;
              k      = 0;
              chk("ack_single", 32'(p_ack & d_ack), 0);
              chk("ack_dealer", 32'(d_ack), 32'(cur.owner));
              chk("owner",      32'(owner), 32'(cur.owner));
            end
          end else begin
            chk("idle_quiet", 32'({vga_plot, done, busy}), 0);
          end
        end
        if (active) begin
          chk("busy", 32'(busy), 1);
          if (k > 0) chk("ack_while_busy", 32'({p_ack, d_ack}), 0);
          if (k < cur.npix)       chk("rom_addr", 32'(rom_addr), cur.base + k);
          else if (cur.npix == 0) chk("rom_idle", 32'(rom_addr), 0);
          if (k >= 1 && k <= cur.npix) begin
            j = k - 1;
            chk("plot",   32'(vga_plot),   1);
            chk("vga_x",  32'(vga_x),      cur.x0 + j % 24);
            chk("vga_y",  32'(vga_y),      cur.y0 + j / 24);
            chk("colour", 32'(vga_colour), 32'(exp_col(14'(cur.base + j), cur.suit)));
          end else begin
            chk("plot_off", 32'(vga_plot), 0);
          end
          if (k == cur.npix + 1) begin
            chk("done", 32'(done), 1);
            active = 1'b0;
          end else begin
            chk("done_early", 32'(done), 0);
          end
          k++;
        end
      end
    end
    rst_prev = rst;
  end

  task automatic set_req(input bit who, input bit v, input logic [5:0] c, input logic [2:0] s);
    if (who) begin
      d_req = v; d_card = c; d_slot = s;
    end else begin
      p_req = v; p_card = c; p_slot = s;
    end
  endtask

  task automatic wait_ack(input bit who);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(who ? d_ack : p_ack) && n < 4000);
    chk(who ? "d_ack_seen" : "p_ack_seen", 32'(who ? d_ack : p_ack), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 4000);
    chk("done_seen", 32'(done), 1);
  endtask

  // Raise a request, hold it through one or two grants, then drop it.
  task automatic drive(input bit who, input logic [5:0] c1, input logic [2:0] s1,
                       input bit two, input logic [5:0] c2, input logic [2:0] s2);
    @(posedge clk); #1 set_req(who, 1'b1, c1, s1);
    wait_ack(who);
    if (two) begin
      @(posedge clk); #1 set_req(who, 1'b1, c2, s2);
      wait_ack(who);
    end
    @(posedge clk); #1;
    if (who) d_req = 1'b0; else p_req = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Both requesters held: player, dealer, player, dealer
    q.push_back(mk(1'b0, 6'h01, 0,     4,   80, 864));
    q.push_back(mk(1'b1, 6'h2A, 7776,  116, 8,  864));
    q.push_back(mk(1'b0, 6'h0D, 10368, 32,  80, 864));
    q.push_back(mk(1'b1, 6'h30, 0,     88,  8,  864));
    fork
      drive(1'b0, 6'h01, 3'd0, 1'b1, 6'h0D, 3'd1);
      drive(1'b1, 6'h2A, 3'd4, 1'b1, 6'h30, 3'd3);
    join
    wait_done();

    // Player suit 1 value 5 slot 2: base 3456, first plot (60,80)
    q.push_back(mk(1'b0, 6'h15, 3456, 60, 80, 864));
    drive(1'b0, 6'h15, 3'd2, 1'b0, 6'h00, 3'd0);
    wait_done();

    // Dealer value 13 slot 0: last address 11231, last plot (27,43)
    q.push_back(mk(1'b1, 6'h2D, 10368, 4, 8, 864));
    drive(1'b1, 6'h2D, 3'd0, 1'b0, 6'h00, 3'd0);
    wait_done();

    // Reset at T400 of a player blit
    q.push_back(mk(1'b0, 6'h23, 1728, 116, 80, 864));
    @(posedge clk); #1 set_req(1'b0, 1'b1, 6'h23, 3'd4);
    wait_ack(1'b0);
    @(posedge clk); #1 p_req = 1'b0;
    repeat (399) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Tie after reset: last_grant is dealer again, so player first
    q.push_back(mk(1'b0, 6'h0C, 9504, 88, 80, 864));
    q.push_back(mk(1'b1, 6'h11, 0,    60, 8,  864));
    fork
      drive(1'b0, 6'h0C, 3'd3, 1'b0, 6'h00, 3'd0);
      drive(1'b1, 6'h11, 3'd2, 1'b0, 6'h00, 3'd0);
    join
    wait_done();

    // Invalid slots: ack, no plots, done at T1
    q.push_back(mk(1'b0, 6'h05, 0, 0, 0, 0));
    drive(1'b0, 6'h05, 3'd5, 1'b0, 6'h00, 3'd0);
    wait_done();
    q.push_back(mk(1'b1, 6'h02, 0, 0, 0, 0));
    drive(1'b1, 6'h02, 3'd7, 1'b0, 6'h00, 3'd0);
    wait_done();

    // Player request withdrawn while the dealer blits: no p_ack
    q.push_back(mk(1'b1, 6'h1F, 0, 32, 8, 864));
    fork
      drive(1'b1, 6'h1F, 3'd1, 1'b0, 6'h00, 3'd0);
      begin
        repeat (20) @(posedge clk);
        #1 set_req(1'b0, 1'b1, 6'h07, 3'd0);
        repeat (300) @(posedge clk);
        #1 p_req = 1'b0;
      end
    join
    wait_done();

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()) + 32'(active), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
